// File: rtl/cdb_writeback_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : cdb_writeback_arbiter_if
// Brief  : FU result inputs, flush, and CDB broadcast outputs of the arbiter.
// Rev    : 1.0  initial release
// ============================================================================
interface cdb_writeback_arbiter_if #(
   parameter int NUM_FU  = 3,
   parameter int NUM_CDB = 2,
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 6,
   parameter int PREG_W  = 6
);
   logic                      flush;
   logic [NUM_FU-1:0]         fu_valid;
   logic [NUM_FU-1:0]         fu_ready;
   logic [NUM_FU*DATA_W-1:0]  fu_data;
   logic [NUM_FU*TAG_W-1:0]   fu_rob_tag;
   logic [NUM_FU*PREG_W-1:0]  fu_preg;
   logic [NUM_CDB-1:0]        cdb_valid;
   logic [NUM_CDB*DATA_W-1:0] cdb_data;
   logic [NUM_CDB*TAG_W-1:0]  cdb_rob_tag;
   logic [NUM_CDB*PREG_W-1:0] cdb_preg;
   logic [NUM_CDB*2-1:0]      cdb_fu_id;
   logic [(2**PREG_W)-1:0]    wb_ready_set;

   modport master (
      input  flush, fu_valid, fu_data, fu_rob_tag, fu_preg,
      output fu_ready, cdb_valid, cdb_data, cdb_rob_tag, cdb_preg, cdb_fu_id, wb_ready_set
   );

   modport slave (
      output flush, fu_valid, fu_data, fu_rob_tag, fu_preg,
      input  fu_ready, cdb_valid, cdb_data, cdb_rob_tag, cdb_preg, cdb_fu_id, wb_ready_set
   );
endinterface
`default_nettype wire

// File: rtl/cdb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module : cdb_writeback_arbiter
// Brief  : One-entry result buffer per FU, round-robin grant of NUM_CDB
//          writeback ports, registered CDB plus preg ready-set mask.
//          Define CDB_LSU_PRIORITY_EN to pin the LSU (FU NUM_FU-1) to port 0.
// Rev    : 1.0  initial release
// ============================================================================
module cdb_writeback_arbiter #(
   parameter int NUM_FU  = 3,
   parameter int NUM_CDB = 2,
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 6,
   parameter int PREG_W  = 6
) (
   input wire                      clk,
   input wire                      reset,
   cdb_writeback_arbiter_if.master bus
);
   localparam int PREG_COUNT = 2**PREG_W;
   localparam int FU_ID_W    = 2;
   localparam int LSU        = NUM_FU - 1;
`ifdef CDB_LSU_PRIORITY_EN
   localparam int RING       = NUM_FU - 1;
`else
   localparam int RING       = NUM_FU;
`endif
   localparam int PTR_W      = (RING > 1) ? $clog2(RING) : 1;

   logic [NUM_FU-1:0]         r_buf_v;
   logic [DATA_W-1:0]         r_buf_data [NUM_FU];
   logic [TAG_W-1:0]          r_buf_tag  [NUM_FU];
   logic [PREG_W-1:0]         r_buf_preg [NUM_FU];
   logic [PTR_W-1:0]          r_rr_ptr;
   logic [NUM_CDB-1:0]        r_cdb_valid;
   logic [NUM_CDB*DATA_W-1:0] r_cdb_data;
   logic [NUM_CDB*TAG_W-1:0]  r_cdb_tag;
   logic [NUM_CDB*PREG_W-1:0] r_cdb_preg;
   logic [NUM_CDB*FU_ID_W-1:0] r_cdb_fu_id;

   logic [NUM_FU-1:0]         w_grant;
   logic [NUM_FU-1:0]         w_ready;
   logic [NUM_FU-1:0]         w_accept;
   int                        w_rank [NUM_FU];
   logic [NUM_CDB-1:0]        w_port_v;
   logic [FU_ID_W-1:0]        w_port_src [NUM_CDB];
   logic                      w_any_rr;
   logic [PTR_W-1:0]          w_rr_next;
   logic [PREG_COUNT-1:0]     w_ready_set;

   // Distance of a ring member from the round-robin pointer in scan order.
   function automatic int ring_pos(input int idx, input logic [PTR_W-1:0] rr);
      int r;
      r = int'(rr);
      return (idx >= r) ? (idx - r) : (idx + RING - r);
   endfunction

   // A buffer's rank is the number of valid buffers ahead of it in scan order;
   // ranks below NUM_CDB win, and the rank doubles as the port number.
   always_comb begin
      int best;
      int lsu_taken;
      best      = -1;
      lsu_taken = 0;
      w_grant   = '0;
      w_any_rr  = 1'b0;
      w_rr_next = r_rr_ptr;
      w_port_v  = '0;
      for (int k = 0; k < NUM_CDB; k++) w_port_src[k] = '0;
      for (int i = 0; i < NUM_FU; i++)  w_rank[i] = 0;
`ifdef CDB_LSU_PRIORITY_EN
      if (r_buf_v[LSU]) begin
         w_grant[LSU]  = 1'b1;
         w_port_v[0]   = 1'b1;
         w_port_src[0] = FU_ID_W'(LSU);
         lsu_taken     = 1;
      end
`endif
      for (int i = 0; i < RING; i++) begin
         w_rank[i] = lsu_taken;
         for (int j = 0; j < RING; j++) begin
            if (r_buf_v[j] && (ring_pos(j, r_rr_ptr) < ring_pos(i, r_rr_ptr)))
               w_rank[i] = w_rank[i] + 1;
         end
         if (r_buf_v[i] && (w_rank[i] < NUM_CDB)) begin
            w_grant[i] = 1'b1;
            w_any_rr   = 1'b1;
            if (w_rank[i] > best) begin
               best      = w_rank[i];
               w_rr_next = PTR_W'((i + 1) % RING);
            end
            for (int k = 0; k < NUM_CDB; k++) begin
               if (w_rank[i] == k) begin
                  w_port_v[k]   = 1'b1;
                  w_port_src[k] = FU_ID_W'(i);
               end
            end
         end
      end
   end

   assign w_ready  = bus.flush ? '1 : (~r_buf_v | w_grant);
   assign w_accept = bus.fu_valid & w_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_buf_v     <= '0;
         r_rr_ptr    <= '0;
         r_cdb_valid <= '0;
         r_cdb_data  <= '0;
         r_cdb_tag   <= '0;
         r_cdb_preg  <= '0;
         r_cdb_fu_id <= '0;
         for (int i = 0; i < NUM_FU; i++) begin
            r_buf_data[i] <= '0;
            r_buf_tag[i]  <= '0;
            r_buf_preg[i] <= '0;
         end
      end else if (bus.flush) begin
         r_buf_v     <= '0;
         r_cdb_valid <= '0;
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (w_accept[i]) begin
               r_buf_v[i]    <= 1'b1;
               r_buf_data[i] <= bus.fu_data[i*DATA_W +: DATA_W];
               r_buf_tag[i]  <= bus.fu_rob_tag[i*TAG_W +: TAG_W];
               r_buf_preg[i] <= bus.fu_preg[i*PREG_W +: PREG_W];
            end else if (w_grant[i]) begin
               r_buf_v[i] <= 1'b0;
            end
         end
         r_cdb_valid <= w_port_v;
         for (int k = 0; k < NUM_CDB; k++) begin
            if (w_port_v[k]) begin
               r_cdb_data[k*DATA_W +: DATA_W]    <= r_buf_data[w_port_src[k]];
               r_cdb_tag[k*TAG_W +: TAG_W]       <= r_buf_tag[w_port_src[k]];
               r_cdb_preg[k*PREG_W +: PREG_W]    <= r_buf_preg[w_port_src[k]];
               r_cdb_fu_id[k*FU_ID_W +: FU_ID_W] <= w_port_src[k];
            end
         end
         if (w_any_rr) r_rr_ptr <= w_rr_next;
      end
   end

   // preg 0 is "no destination": broadcast for the ROB but never marks ready.
   always_comb begin
      w_ready_set = '0;
      for (int k = 0; k < NUM_CDB; k++) begin
         if (r_cdb_valid[k]) w_ready_set[r_cdb_preg[k*PREG_W +: PREG_W]] = 1'b1;
      end
      w_ready_set[0] = 1'b0;
   end

   assign bus.fu_ready     = w_ready;
   assign bus.cdb_valid    = r_cdb_valid;
   assign bus.cdb_data     = r_cdb_data;
   assign bus.cdb_rob_tag  = r_cdb_tag;
   assign bus.cdb_preg     = r_cdb_preg;
   assign bus.cdb_fu_id    = r_cdb_fu_id;
   assign bus.wb_ready_set = w_ready_set;
endmodule
`default_nettype wire
